// File: rtl/mod_n_serial.sv
// Serial divisibility checker: running remainder of a framed bit stream modulo MOD, MSB- or LSB-first per frame.
// Latency: 1 cycle from an accepted bit to rem/div/bit_cnt; done pulses in the cycle the final remainder appears.
// Backpressure: none; one bit accepted per cycle whenever in_valid is high.
module mod_n_serial #(
    parameter  int MOD       = 3,
    parameter  int FRAME_LEN = 12,
    localparam int RW        = $clog2(MOD),
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in,
    input  logic          in_valid,
    input  logic          clear,
    input  logic          lsb_first,
    output logic [RW-1:0] rem,
    output logic          div,
    output logic [CW-1:0] bit_cnt,
    output logic          done
);

    // Frame phase. S_START covers both "nothing received yet" and "previous
    // frame finished and its done pulse has been shown": either way the next
    // accepted bit opens a fresh frame.
    typedef enum logic [1:0] {
        S_START,
        S_ACTIVE,
        S_DONE
    } state_t;

    localparam logic [RW:0]   MOD_X = (RW + 1)'(MOD);
    localparam logic [CW-1:0] LEN_C = CW'(FRAME_LEN);
    localparam logic [CW-1:0] CNT_1 = CW'(1);
    localparam logic [RW-1:0] ONE_R = RW'(1);

    state_t        state;
    state_t        state_n;
    logic [RW-1:0] weight;
    logic [RW-1:0] weight_n;
    logic          order;
    logic          order_n;
    logic [RW-1:0] rem_n;
    logic [CW-1:0] cnt_n;

    logic          start;
    logic [RW-1:0] base_rem;
    logic [RW-1:0] base_w;
    logic          use_lsb;
    logic [RW:0]   msb_sum;
    logic [RW:0]   lsb_sum;
    logic [RW:0]   dbl_w;
    logic [RW-1:0] step_rem;
    logic [RW-1:0] step_w;
    logic [CW-1:0] step_cnt;

    // Both operands are already < MOD, so every sum is < 2*MOD and one
    // conditional subtract is a full reduction.
    function automatic logic [RW-1:0] reduce(input logic [RW:0] x);
        logic [RW:0] t;
        t = (x >= MOD_X) ? (x - MOD_X) : x;
        return t[RW-1:0];
    endfunction

    // Remainder/weight update for one accepted bit; a frame start (or clear)
    // substitutes the zero remainder, unit weight and live lsb_first.
    always_comb begin
        start    = clear || (state != S_ACTIVE);
        base_rem = start ? '0 : rem;
        base_w   = start ? ONE_R : weight;
        use_lsb  = start ? lsb_first : order;
        msb_sum  = {base_rem, 1'b0} + {{RW{1'b0}}, in};
        lsb_sum  = {1'b0, base_rem} + (in ? {1'b0, base_w} : '0);
        dbl_w    = {base_w, 1'b0};
        step_rem = use_lsb ? reduce(lsb_sum) : reduce(msb_sum);
        step_w   = use_lsb ? reduce(dbl_w) : base_w;
        step_cnt = start ? CNT_1 : (bit_cnt + CNT_1);
    end

    // Next-state selection: clear beats in_valid, and a clear never lets the
    // frame enter S_DONE so done stays low in the cycle after a clear.
    always_comb begin
        state_n  = state;
        rem_n    = rem;
        weight_n = weight;
        order_n  = order;
        cnt_n    = bit_cnt;
        if (in_valid) begin
            rem_n    = step_rem;
            weight_n = step_w;
            order_n  = use_lsb;
            cnt_n    = step_cnt;
            if (step_cnt == LEN_C) begin
                state_n = clear ? S_START : S_DONE;
            end else begin
                state_n = S_ACTIVE;
            end
        end else if (clear) begin
            rem_n    = '0;
            weight_n = ONE_R;
            cnt_n    = '0;
            state_n  = S_START;
        end else if (state == S_DONE) begin
            state_n = S_START;
        end
    end

    // State registers; div is registered from the same next remainder so it
    // can never disagree with rem.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_START;
            rem     <= '0;
            div     <= 1'b1;
            bit_cnt <= '0;
            weight  <= ONE_R;
            order   <= 1'b0;
        end else begin
            state   <= state_n;
            rem     <= rem_n;
            div     <= (rem_n == '0);
            bit_cnt <= cnt_n;
            weight  <= weight_n;
            order   <= order_n;
        end
    end

    assign done = (state == S_DONE);

endmodule

// File: tb/tb_mod_n_serial.sv
// Directed bench for mod_n_serial: three instances (mod 3, mod 5 / 4-bit frames, mod 7) share one stimulus bus.
// Latency: every vector is checked half a cycle after the edge that consumed it.
// Backpressure: not applicable; the bench drives in_valid directly.
module tb_mod_n_serial;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;
    logic       lsb_first = 1'b0;

    logic [1:0] rem3;
    logic       div3;
    logic [3:0] cnt3;
    logic       done3;
    logic [2:0] rem5;
    logic       div5;
    logic [2:0] cnt5;
    logic       done5;
    logic [2:0] rem7;
    logic       div7;
    logic [3:0] cnt7;
    logic       done7;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mod_n_serial #(.MOD(3), .FRAME_LEN(12)) u3 (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .clear(clear),
        .lsb_first(lsb_first), .rem(rem3), .div(div3), .bit_cnt(cnt3), .done(done3)
    );

    mod_n_serial #(.MOD(5), .FRAME_LEN(4)) u5 (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .clear(clear),
        .lsb_first(lsb_first), .rem(rem5), .div(div5), .bit_cnt(cnt5), .done(done5)
    );

    mod_n_serial #(.MOD(7), .FRAME_LEN(12)) u7 (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .clear(clear),
        .lsb_first(lsb_first), .rem(rem7), .div(div7), .bit_cnt(cnt7), .done(done7)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, return at the next falling edge.
    task automatic drive(input logic r, input logic c, input logic v, input logic b, input logic l);
        reset     = r;
        clear     = c;
        in_valid  = v;
        din       = b;
        lsb_first = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int b2[3]  = '{1, 1, 0};
        int r2[3]  = '{1, 0, 0};
        int d2[3]  = '{0, 1, 1};
        int b3[3]  = '{0, 1, 1};
        int r3[3]  = '{0, 2, 0};
        int r4a[3] = '{1, 3, 2};
        int b4b[4] = '{1, 0, 1, 0};
        int r4b[4] = '{1, 2, 0, 0};
        int r5[4]  = '{1, 3, 0, 1};

        @(negedge clk);

        // Reset values
        drive(1, 0, 0, 0, 0);
        chk("rst_rem", rem3, 0);
        chk("rst_div", div3, 1);
        chk("rst_cnt", cnt3, 0);
        chk("rst_done", done3, 0);

        // Divide-by-3 instance, MSB-first 1,1,0 = 6
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, b2[i][0], 0);
            chk($sformatf("m3_msb_rem%0d", i), rem3, r2[i]);
            chk($sformatf("m3_msb_div%0d", i), div3, d2[i]);
            chk($sformatf("m3_msb_cnt%0d", i), cnt3, i + 1);
        end

        // Divide-by-3 instance, LSB-first 0,1,1 = 6
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, b3[i][0], 1);
            chk($sformatf("m3_lsb_rem%0d", i), rem3, r3[i]);
        end
        chk("m3_lsb_div", div3, 1);

        // Divide-by-5 instance, FRAME_LEN 4: 1,1,1,1 = 15, idle gap, then 1,0,1,0 = 10, then 1
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 0);
            chk($sformatf("m5_rem%0d", i), rem5, r4a[i]);
            chk($sformatf("m5_done%0d", i), done5, 0);
        end
        drive(0, 0, 1, 1, 0);
        chk("m5_end_rem", rem5, 0);
        chk("m5_end_div", div5, 1);
        chk("m5_end_cnt", cnt5, 4);
        chk("m5_end_done", done5, 1);
        drive(0, 0, 0, 0, 0);
        chk("m5_idle_done", done5, 0);
        chk("m5_idle_rem", rem5, 0);
        chk("m5_idle_cnt", cnt5, 4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, b4b[i][0], 0);
            chk($sformatf("m5_f2_rem%0d", i), rem5, r4b[i]);
            chk($sformatf("m5_f2_cnt%0d", i), cnt5, i + 1);
        end
        chk("m5_f2_done", done5, 1);
        drive(0, 0, 1, 1, 0);
        chk("m5_next_rem", rem5, 1);
        chk("m5_next_cnt", cnt5, 1);
        chk("m5_next_done", done5, 0);

        // Divide-by-7 instance, LSB-first 1,1,1,1: weights 1,2,4,1
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1, 1);
            chk($sformatf("m7_lsb_rem%0d", i), rem7, r5[i]);
        end

        // Divide-by-3 gap with lsb_first toggled mid-frame: MSB 1,(gap),0,1 = 5
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0);
        chk("gap_first_rem", rem3, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1);
            chk($sformatf("gap_hold_rem%0d", i), rem3, 1);
            chk($sformatf("gap_hold_cnt%0d", i), cnt3, 1);
        end
        drive(0, 0, 1, 0, 1);
        chk("gap_second_rem", rem3, 2);
        drive(0, 0, 1, 1, 1);
        chk("gap_third_rem", rem3, 2);
        chk("gap_third_cnt", cnt3, 3);

        // clear with a bit: new frame starts with that bit, lsb_first sampled
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0);
        chk("clr_pre_rem", rem3, 2);
        drive(0, 1, 1, 1, 1);
        chk("clr_v_rem", rem3, 1);
        chk("clr_v_cnt", cnt3, 1);
        chk("clr_v_done", done3, 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0);
        chk("clr_order_rem7", rem7, 3);
        chk("clr_order_cnt7", cnt7, 3);

        // clear alone
        drive(0, 1, 0, 0, 0);
        chk("clr_rem", rem3, 0);
        chk("clr_div", div3, 1);
        chk("clr_cnt", cnt3, 0);

        // reset mid-frame beats a valid bit
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0);
        drive(1, 0, 1, 1, 0);
        chk("rst_mid_rem", rem3, 0);
        chk("rst_mid_div", div3, 1);
        chk("rst_mid_cnt", cnt3, 0);

        // reset, clear and in_valid together
        drive(0, 0, 1, 1, 0);
        drive(1, 1, 1, 1, 1);
        chk("rst_all_rem", rem3, 0);
        chk("rst_all_div", div3, 1);
        chk("rst_all_cnt", cnt3, 0);
        chk("rst_all_done5", done5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_n_serial.md
# mod_n_serial

Parametrised serial divisibility checker: consumes a bit stream one bit per accepted cycle and tracks the running remainder of the received value modulo `MOD`. It supports both MSB-first and LSB-first framing, selectable per frame. It is the generalised successor of the team's fixed divide-by-3 FSM. It sits after a serial receiver and flags, frame by frame, whether the received word is a multiple of `MOD`.

## Interface
Parameters:
- `MOD`, 3: modulus, integer ≥ 2.
- `FRAME_LEN`, 12: number of bits per frame, ≥ 1.
- `RW`, `$clog2(MOD)`: remainder width (derived, not overridden).
- `CW`, `$clog2(FRAME_LEN+1)`: bit-counter width (derived).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in` in 1: serial data bit.
- `in_valid` in 1: `in` is accepted on this edge.
- `clear` in 1: abort the current frame and restart it.
- `lsb_first` in 1: frame bit order. Sampled only with the first bit of a frame.
- `rem` out RW: running remainder, registered.
- `div` out 1: registered; high when `rem == 0`.
- `bit_cnt` out CW: number of bits accepted in the current frame.
- `done` out 1: one-cycle pulse; the frame is complete and `rem`/`div` are final.

## Operation
- **States:** IDLE/START (`bit_cnt == 0`) → ACTIVE (`0 < bit_cnt < FRAME_LEN`) → DONE (`bit_cnt == FRAME_LEN`, lasts one cycle when the stream is back-to-back).
- **Frame start:** the first accepted bit of a frame does all of the following:
  - latches `lsb_first` into internal `order`;
  - initialises `weight` to 1;
  - computes `rem` from a zero base.
- **MSB-first update:** `rem_n = (2*rem + in) mod MOD`.
  - The intermediate is RW+1 bits and always < 2*MOD, so it is reduced with a single conditional subtract of `MOD`.
- **LSB-first update:**
  - `rem_n = (rem + (in ? weight : 0)) mod MOD`.
  - `weight_n = (2*weight) mod MOD`.
  - Each sum is < 2*MOD, so each is reduced with a single conditional subtract.
- **Hold:** when `in_valid = 0`, all state holds and `done` deasserts.
- **Frame end:** when the accepted bit makes `bit_cnt` reach `FRAME_LEN`, `done = 1` on the following cycle.
  - The next accepted bit begins a new frame: `bit_cnt` becomes 1 and `rem` is computed from that bit alone.
  - `done` is a single-cycle pulse even if `in_valid` stays low afterwards; `rem`, `div` and `bit_cnt` hold.
- **`clear`:** returns to frame start with `rem = 0`, `div = 1`, `bit_cnt = 0`, `weight = 1`.
  - If `in_valid` is high in the same cycle, that bit is accepted as the first bit of the new frame, and `lsb_first` is sampled.
  - `done` is forced to 0.
- **Precedence:** `reset` > `clear` > `in_valid`.
- **`lsb_first` mid-frame:** changes are ignored until the next frame start.

## Timing
- **Reset values** (applied at the edge where `reset = 1`, including mid-frame):
  - `rem = 0`, `div = 1`, `bit_cnt = 0`, `done = 0`;
  - internal `weight = 1`, `order = 0`.
- **Latency:** 1 cycle. A bit accepted at edge k is reflected in `rem`, `div` and `bit_cnt` after edge k.
- **`div`** is registered alongside `rem` and is never inconsistent with it.
- **`done`** is asserted in the same cycle that `rem` first shows the final frame value.
- **Throughput:** one bit per cycle; no back-pressure.

## Test plan
- **MOD=3 basic, both orders:**
  - MSB-first, bits 1,1,0 (=6): `rem` 1,0,0; `div` 0,1,1.
  - LSB-first, bits 0,1,1 (=6): `rem` 0,2,0.
- **MOD=5, FRAME_LEN=4, MSB-first frame boundary:**
  - Bits 1,1,1,1 (=15): `rem` 1,3,2,0; `done` pulses with `rem = 0`, `div = 1`.
  - Next bit 1: `rem = 1`, `bit_cnt = 1`, `done = 0`.
- **MOD=7, LSB-first weight wrap:**
  - Bits 1,1,1 (=7): `rem` 1,3,0.
  - Continuing to bit 4 = 1 (value 15): `weight` wraps 8 mod 7 = 1, so `rem = 1`.
- **Gaps and mode sampling:**
  - MOD=3, MSB-first, bits 1,0 with `in_valid` low for 3 cycles between them: `rem` holds 1 through the gap, then becomes 2.
  - Toggling `lsb_first` mid-frame has no effect.
- **`clear` and `reset` mid-frame** (MOD=3, after bits 1,0 with `rem = 2`):
  - `clear` with `in_valid = 1`, `in = 1`: `rem = 1`, `bit_cnt = 1`.
  - `reset` mid-frame: `rem = 0`, `div = 1`, `bit_cnt = 0`.
  - `reset`, `clear` and `in_valid` all high together: reset values.
